// File: rtl/hs_tx_pkg.sv
// Shared definitions for the 4-phase handshake transmitter and its synchronizer.
// State encoding, default synchronizer depth and counter width helper.
package hs_tx_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_REL  = 2'd2;

    localparam int DEF_SYNC_STAGES = 2;

    // Bits needed to hold values 0..v-1, never less than one bit.
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/hs_tx_sync_bit.sv
// Single-bit multi-flop synchronizer; latency STAGES clk_i edges, no backpressure.
// Async active-high reset clears the whole chain to 0.
module sync_bit
    import hs_tx_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/hs_tx.sv
// Source end of the 4-phase req/ack CDC handshake: holds a word on data_out while req_out is high.
// Accept takes one edge; tx_ready stays low while busy or while the synchronized ack is still high.
module hs_tx
    import hs_tx_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT     = 255
) (
    input  logic              clkA,
    input  logic              resetA,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              req_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              ack_in,
    output logic              busy,
    output logic              done_pulse,
    output logic              err,
    input  logic              err_clr
);

    localparam int              CNT_W   = clog2_min1(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic              ack_s;
    logic [1:0]        state_q, state_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              abort_q, abort_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              tmo_hit;

    sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk_i (clkA),
        .rst_i (resetA),
        .d_i   (ack_in),
        .q_o   (ack_s)
    );

    assign tx_ready   = (state_q == ST_IDLE) & ~ack_s;
    assign busy       = (state_q != ST_IDLE);
    assign req_out    = req_q;
    assign data_out   = data_q;
    assign done_pulse = done_q;
    assign err        = err_q;

    // cnt_inc is the number of cycles spent in the state including this one,
    // so an abort leaves at most TIMEOUT cycles in REQ or REL.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign tmo_hit = (TIMEOUT != 0) && (cnt_inc == CNT_MAX);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = err_clr ? 1'b0 : err_q;
        abort_d = abort_q;
        cnt_d   = cnt_inc;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (tx_valid && tx_ready) begin
                    data_d  = tx_data;
                    req_d   = 1'b1;
                    abort_d = 1'b0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_REL;
                end else if (tmo_hit) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_REL;
                end
            end
            ST_REL: begin
                // An aborted request still drains through REL but never reports done.
                if (!ack_s) begin
                    done_d  = ~abort_q;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clkA or posedge resetA) begin
        if (resetA) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            abort_q <= abort_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hs_tx.sv
// Directed bench for hs_tx with TIMEOUT=10; ack_in is driven step by step as the far-side responder.
module tb_hs_tx;

    logic       clkA;
    logic       resetA;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       req_out;
    logic [7:0] data_out;
    logic       ack_in;
    logic       busy;
    logic       done_pulse;
    logic       err;
    logic       err_clr;

    int tests = 0;
    int fails = 0;

    hs_tx #(.DATA_W(8), .SYNC_STAGES(2), .TIMEOUT(10)) dut (
        .clkA       (clkA),
        .resetA     (resetA),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .req_out    (req_out),
        .data_out   (data_out),
        .ack_in     (ack_in),
        .busy       (busy),
        .done_pulse (done_pulse),
        .err        (err),
        .err_clr    (err_clr)
    );

    initial begin
        clkA = 1'b0;
        forever #5 clkA = ~clkA;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clkA);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        resetA   = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        ack_in   = 1'b0;
        err_clr  = 1'b0;

        // Reset state
        #50;
        chk("rst_req", req_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_done", done_pulse, 0);
        @(negedge clkA);
        resetA = 1'b0;
        step(3);
        chk("idle_req", req_out, 0);
        chk("idle_busy", busy, 0);

        // Nominal transfer of A5
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        chk("nom_req_rise", req_out, 1);
        chk("nom_data", data_out, 8'hA5);
        chk("nom_busy", busy, 1);
        chk("nom_ready_low", tx_ready, 0);
        step(2);
        ack_in = 1'b1;
        step(2);
        chk("nom_req_hold", req_out, 1);
        step(1);
        chk("nom_req_fall", req_out, 0);
        chk("nom_data_rel", data_out, 8'hA5);
        step(2);
        ack_in = 1'b0;
        step(2);
        chk("nom_no_early_done", done_pulse, 0);
        chk("nom_busy_rel", busy, 1);
        step(1);
        chk("nom_done", done_pulse, 1);
        chk("nom_ready_at_done", tx_ready, 1);
        chk("nom_busy_done", busy, 0);
        step(1);
        chk("nom_done_1cyc", done_pulse, 0);
        chk("nom_data_after", data_out, 8'hA5);

        // Back-to-back with tx_valid held
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        step(1);
        chk("b2b_req1", req_out, 1);
        chk("b2b_data1", data_out, 8'h01);
        tx_data = 8'h02;
        step(2);
        chk("b2b_data1_hold", data_out, 8'h01);
        ack_in = 1'b1;
        step(3);
        chk("b2b_req1_fall", req_out, 0);
        step(2);
        ack_in = 1'b0;
        step(3);
        chk("b2b_done1", done_pulse, 1);
        chk("b2b_req_low_at_done", req_out, 0);
        chk("b2b_data1_done", data_out, 8'h01);
        step(1);
        tx_valid = 1'b0;
        chk("b2b_req2", req_out, 1);
        chk("b2b_data2", data_out, 8'h02);
        chk("b2b_done1_end", done_pulse, 0);
        step(2);
        ack_in = 1'b1;
        step(3);
        chk("b2b_req2_fall", req_out, 0);
        step(2);
        ack_in = 1'b0;
        step(3);
        chk("b2b_done2", done_pulse, 1);
        step(1);
        chk("b2b_idle", busy, 0);
        chk("b2b_no_reaccept", req_out, 0);

        // Stale ack while idle
        ack_in = 1'b1;
        step(1);
        chk("stale_ready_e1", tx_ready, 1);
        step(1);
        chk("stale_ready_e2", tx_ready, 0);
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        step(4);
        chk("stale_no_req", req_out, 0);
        chk("stale_no_busy", busy, 0);
        ack_in = 1'b0;
        step(1);
        chk("stale_ready_still0", tx_ready, 0);
        step(1);
        chk("stale_ready_back", tx_ready, 1);
        chk("stale_req_before", req_out, 0);
        step(1);
        tx_valid = 1'b0;
        chk("stale_req", req_out, 1);
        chk("stale_data", data_out, 8'h5A);
        step(2);
        ack_in = 1'b1;
        step(3);
        chk("stale_req_fall", req_out, 0);
        step(2);
        ack_in = 1'b0;
        step(3);
        chk("stale_done", done_pulse, 1);
        step(2);

        // REQ timeout: ack never arrives
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        chk("tmo_req_rise", req_out, 1);
        step(9);
        chk("tmo_req_9", req_out, 1);
        chk("tmo_err_9", err, 0);
        step(1);
        chk("tmo_req_10", req_out, 0);
        chk("tmo_err", err, 1);
        chk("tmo_busy_rel", busy, 1);
        step(1);
        chk("tmo_idle", busy, 0);
        chk("tmo_no_done", done_pulse, 0);
        chk("tmo_data_hold", data_out, 8'hC3);
        step(2);
        chk("tmo_err_sticky", err, 1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("tmo_err_clr", err, 0);

        // REL timeout: ack stuck high after req falls
        tx_data  = 8'h77;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        ack_in   = 1'b1;
        step(3);
        chk("rel_req_fall", req_out, 0);
        chk("rel_busy", busy, 1);
        step(9);
        chk("rel_busy_9", busy, 1);
        chk("rel_err_9", err, 0);
        step(1);
        chk("rel_idle", busy, 0);
        chk("rel_err", err, 1);
        chk("rel_no_done", done_pulse, 0);
        chk("rel_ready_gated", tx_ready, 0);
        ack_in = 1'b0;
        step(2);
        chk("rel_ready_back", tx_ready, 1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("rel_err_clr", err, 0);

        // Reset asserted while in REL
        tx_data  = 8'h99;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        ack_in   = 1'b1;
        step(3);
        chk("mid_in_rel", busy, 1);
        #1;
        resetA = 1'b1;
        #1;
        chk("mid_req", req_out, 0);
        chk("mid_busy", busy, 0);
        chk("mid_data", data_out, 0);
        ack_in = 1'b0;
        @(negedge clkA);
        resetA = 1'b0;
        step(1);
        chk("mid_ready", tx_ready, 1);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        chk("mid_req_new", req_out, 1);
        chk("mid_data_new", data_out, 8'h3C);
        step(2);
        ack_in = 1'b1;
        step(3);
        chk("mid_req_fall", req_out, 0);
        step(2);
        ack_in = 1'b0;
        step(3);
        chk("mid_done", done_pulse, 1);
        chk("mid_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
